mat_result_drain: RTL and testbench
===================================

Name: mat_result_drain

Overview:
- Downstream stage of the systolic matrix-multiply `control` unit.
- Captures the flattened N×N result matrix (`o_C` of `control`, 2W bits per element) on a completion strobe.
- Serializes the captured matrix one element per accepted beat over a valid/ready stream toward the host/output port.
- Decouples the array from host backpressure through a single-frame shadow buffer.

Parameters:
- W, 32: operand width of the array; each result element is 2*W bits.
- N, 3: matrix dimension; one frame is N*N elements.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_C_valid  in  1  single-cycle strobe from control: i_C holds a complete result this cycle
- i_C  in  2*W*N*N  flattened result matrix; element (r,c), k=r*N+c, at bits [(N*N-1-k)*2W +: 2W] (element 00 at MSB)
- o_ready  out  1  drain can accept a new frame (registered)
- o_data  out  2*W  current element
- o_valid  out  1  o_data valid
- i_ready  in  1  consumer accepts o_data
- o_row  out  $clog2(N) (min 1)  row index of o_data
- o_col  out  $clog2(N) (min 1)  column index of o_data
- o_last  out  1  o_data is element (N-1,N-1)
- o_frame_cnt  out  16  frames fully drained, wraps at 2^16
- o_overrun  out  1  sticky: a frame was dropped

Behaviour:
- Reset (async, immediate):
  - State is IDLE.
  - o_ready=1, o_valid=0, o_data=0, o_row=0, o_col=0, o_last=0, o_frame_cnt=0, o_overrun=0.
  - Shadow buffer is cleared to 0.
- FSM states: IDLE, STREAM.
- IDLE:
  - o_ready=1, o_valid=0.
  - On i_C_valid: latch i_C into the shadow buffer, set row=col=0, go to STREAM.
  - Next cycle: o_valid=1, o_ready=0. Strobe-to-first-valid latency is 1 cycle.
- STREAM:
  - o_valid=1; o_data = shadow element (row,col); o_last = (row==N-1 && col==N-1).
  - Beat fires when o_valid && i_ready. On a beat, col increments; at col==N-1, col wraps to 0 and row increments.
  - While i_ready=0, o_data, o_row, o_col and o_last hold stable; o_valid is never withdrawn without a beat.
  - Beat with o_last=1: o_frame_cnt increments, go to IDLE. Next cycle o_valid=0, o_ready=1.
- Throughput: one element per cycle with i_ready held high, so N*N cycles per frame. Minimum frame-to-frame spacing is N*N+1 cycles (one IDLE cycle).
- Overrun:
  - i_C_valid while in STREAM (including the last-beat cycle) is ignored. The shadow buffer is untouched and o_overrun is set.
  - o_overrun clears only on reset.
- i_C is sampled only in the strobe cycle; it may change freely afterwards.
- Reset mid-stream: o_valid drops asynchronously and the partial frame is discarded; o_frame_cnt is not incremented.
- o_frame_cnt wraps 0xFFFF → 0x0000 without flagging.
- All outputs are registered or decoded from registered state; there is no combinational path from i_ready or i_C_valid to any output.

Decomposition:
- Shared package `mat_pkg` holds the W/N defaults, the element-index helper (k = r*N+c), the bit-offset function for the flattened layout, and the FSM state typedef. The upstream loader and `control` reuse the same layout function.
- One natural sub-module, `mat_idx_counter`: row/col counter with enable, wrap and last-flag. It is reused by the upstream loader.

Test Plan:
- Ordering, N=3, W=32:
  - Stimulus: element k = k+1 (64-bit), strobe, i_ready=1.
  - Required: o_data 1..9 on 9 consecutive cycles; (row,col) (0,0)..(2,2); o_last only on 9; o_frame_cnt=1; o_valid low the following cycle.
- Backpressure:
  - Stimulus: i_ready toggles 1,0,0,1,… during a frame of 0xFFFFFFFE00000001 elements.
  - Required: o_data stable during stalls; exactly 9 beats accepted, no duplicates or skips.
- Overrun:
  - Stimulus: strobe a second frame (all 0xAAAA…) at beat 4 of the first frame.
  - Required: remaining beats carry first-frame values; o_overrun=1 and stays 1; o_frame_cnt=1.
- Back-to-back frames:
  - Stimulus: strobe a new frame in the cycle o_ready returns to 1.
  - Required: both frames drained intact; o_frame_cnt=2; o_overrun=0.
- Reset mid-operation:
  - Stimulus: assert i_rst asynchronously (off-edge) at beat 5.
  - Required: o_valid=0 before the next clock edge; all outputs at reset values; a subsequent frame drains from (0,0).
- All-zero and all-ones matrices:
  - Stimulus: one frame with every element 0, then one with every element all-ones (2^64-1).
  - Required: each frame gives exactly 9 beats with o_data constant at that frame's value (0, then all ones); o_frame_cnt=2.

Source files
------------

// File: rtl/mat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mat_pkg                                                      |
// | Description : Shared definitions for the systolic matrix-multiply blocks:  |
// |               default operand width and matrix size, the row/col to        |
// |               element-index helper, the bit offset of an element in the    |
// |               flattened matrix bus (element 00 at the MSB end), and the    |
// |               result-drain FSM state type.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mat_pkg;

  localparam int MAT_W = 32;
  localparam int MAT_N = 3;

  typedef logic [0:0] drain_state_t;
  localparam drain_state_t ST_IDLE   = 1'b0;
  localparam drain_state_t ST_STREAM = 1'b1;

  // Index width for a 0..n-1 counter; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Row-major linear element index.
  function automatic int elem_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction

  // LSB position of element (r,c) in a flattened n*n bus of ew-bit elements.
  function automatic int elem_off(input int r, input int c, input int n, input int ew);
    return (n * n - 1 - elem_idx(r, c, n)) * ew;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mat_idx_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mat_idx_counter                                              |
// | Description : Row-major (row,col) walker over an N x N matrix.             |
// |               clr_i forces (0,0); en_i advances col, wrapping into row;    |
// |               after (N-1,N-1) it wraps back to (0,0).                      |
// | Ports       : clk_i, rst_i (async, active-high), clr_i, en_i,              |
// |               row_o, col_o (current index), last_o (index is N-1,N-1).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mat_idx_counter
  import mat_pkg::*;
#(
  parameter int N = MAT_N
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  output logic [idx_w(N)-1:0]   row_o,
  output logic [idx_w(N)-1:0]   col_o,
  output logic                  last_o
);

  localparam int            IW    = idx_w(N);
  localparam logic [IW-1:0] c_MAX = IW'(N - 1);
  localparam logic [IW-1:0] c_ONE = IW'(1);

  logic [IW-1:0] row_q, row_d;
  logic [IW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == c_MAX) begin
        col_d = '0;
        row_d = (row_q == c_MAX) ? '0 : row_q + c_ONE;
      end else begin
        col_d = col_q + c_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == c_MAX) && (col_q == c_MAX);

endmodule
`default_nettype wire

// File: rtl/mat_result_drain.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mat_result_drain                                             |
// | Description : Captures a flattened N x N result matrix (2W-bit elements)   |
// |               on a completion strobe into a single-frame shadow buffer and |
// |               serializes it row-major over a valid/ready stream.           |
// |               Strobes arriving while a frame is still streaming are        |
// |               dropped and flagged on the sticky overrun output.            |
// | Ports       : i_clk, i_rst (async, active-high)                            |
// |               i_C_valid / i_C   : frame capture strobe and matrix bus      |
// |               o_ready           : able to accept a new frame               |
// |               o_valid / o_data / i_ready : element stream handshake        |
// |               o_row, o_col, o_last : index of current element              |
// |               o_frame_cnt       : frames fully drained (wraps at 2^16)     |
// |               o_overrun         : sticky dropped-frame flag                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mat_result_drain
  import mat_pkg::*;
#(
  parameter int W = MAT_W,
  parameter int N = MAT_N
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_C_valid,
  input  logic [2*W*N*N-1:0]     i_C,
  output logic                   o_ready,
  output logic [2*W-1:0]         o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [idx_w(N)-1:0]    o_row,
  output logic [idx_w(N)-1:0]    o_col,
  output logic                   o_last,
  output logic [15:0]            o_frame_cnt,
  output logic                   o_overrun
);

  localparam int EW = 2 * W;
  localparam int CW = EW * N * N;
  localparam int IW = idx_w(N);
  localparam int OW = (CW > 1) ? $clog2(CW) : 1;

  drain_state_t  state_q, state_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          overrun_q, overrun_d;

  logic          w_idle;
  logic          w_stream;
  logic          w_accept;
  logic          w_beat;
  logic          w_last;
  logic [IW-1:0] w_row;
  logic [IW-1:0] w_col;
  logic [OW-1:0] w_off;

  assign w_idle   = (state_q == ST_IDLE);
  assign w_stream = (state_q == ST_STREAM);
  assign w_accept = w_idle && i_C_valid;
  assign w_beat   = w_stream && i_ready;

  // Accepting a frame rewinds the walker to (0,0); the last beat wraps it
  // back there anyway, so both paths leave it ready for the next frame.
  mat_idx_counter #(
    .N (N)
  ) u_idx (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (w_accept),
    .en_i   (w_beat),
    .row_o  (w_row),
    .col_o  (w_col),
    .last_o (w_last)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    case (state_q)
      ST_IDLE: begin
        if (i_C_valid) begin
          shadow_d = i_C;
          state_d  = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // The shadow buffer is busy until the last beat has left, so any
        // strobe here (including the last-beat cycle) is a dropped frame.
        if (i_C_valid) begin
          overrun_d = 1'b1;
        end
        if (i_ready && w_last) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Element select is driven only by registered index and buffer, so the
  // stream outputs stay stable across stalls without extra holding logic.
  assign w_off = OW'(elem_off(int'(w_row), int'(w_col), N, EW));

  assign o_ready     = w_idle;
  assign o_valid     = w_stream;
  assign o_data      = shadow_q[w_off +: EW];
  assign o_row       = w_row;
  assign o_col       = w_col;
  assign o_last      = w_stream && w_last;
  assign o_frame_cnt = frame_cnt_q;
  assign o_overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mat_result_drain.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mat_result_drain                                          |
// | Description : Self-checking bench for mat_result_drain (W=32, N=3).        |
// |               Expected stream is kept as a queue of (data,row,col,last)    |
// |               entries built from each accepted frame.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mat_result_drain;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int NN = N * N;
  localparam int EW = 2 * W;
  localparam int IW = 2;
  localparam int CW = EW * NN;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_C_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [CW-1:0] i_C = '0;
  logic          o_ready;
  logic          o_valid;
  logic          o_last;
  logic          o_overrun;
  logic [EW-1:0] o_data;
  logic [IW-1:0] o_row;
  logic [IW-1:0] o_col;
  logic [15:0]   o_frame_cnt;

  mat_result_drain #(
    .W (W),
    .N (N)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_C_valid   (i_C_valid),
    .i_C         (i_C),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_row       (o_row),
    .o_col       (o_col),
    .o_last      (o_last),
    .o_frame_cnt (o_frame_cnt),
    .o_overrun   (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [EW-1:0] data;
    int            row;
    int            col;
    bit            last;
  } beat_t;

  beat_t         exp_q[$];
  logic [15:0]   m_cnt;
  bit            m_ovr;
  int            n_checks;
  int            n_errors;
  int            n_beats;
  logic [EW-1:0] elems[NN];

  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] pack_frame();
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < NN; k++) c[(NN-1-k)*EW +: EW] = elems[k];
    return c;
  endfunction

  task automatic fill_const(input logic [EW-1:0] v);
    for (int k = 0; k < NN; k++) elems[k] = v;
  endtask

  task automatic fill_rand();
    for (int k = 0; k < NN; k++) elems[k] = {$urandom(), $urandom()};
  endtask

  task automatic push_frame();
    for (int k = 0; k < NN; k++) exp_q.push_back('{elems[k], k / N, k % N, (k == NN - 1)});
  endtask

  task automatic check_outputs();
    bit busy;
    busy = (exp_q.size() > 0);
    chk("valid", {63'd0, o_valid}, {63'd0, busy});
    chk("ready", {63'd0, o_ready}, {63'd0, !busy});
    chk("frame_cnt", {48'd0, o_frame_cnt}, {48'd0, m_cnt});
    chk("overrun", {63'd0, o_overrun}, {63'd0, m_ovr});
    if (busy && o_valid) begin
      chk("data", o_data, exp_q[0].data);
      chk("row", {62'd0, o_row}, 64'(exp_q[0].row));
      chk("col", {62'd0, o_col}, 64'(exp_q[0].col));
      chk("last", {63'd0, o_last}, {63'd0, exp_q[0].last});
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
    chk({tag, "_ready"}, {63'd0, o_ready}, 64'd1);
    chk({tag, "_data"}, o_data, 64'd0);
    chk({tag, "_row"}, {62'd0, o_row}, 64'd0);
    chk({tag, "_col"}, {62'd0, o_col}, 64'd0);
    chk({tag, "_last"}, {63'd0, o_last}, 64'd0);
    chk({tag, "_fcnt"}, {48'd0, o_frame_cnt}, 64'd0);
    chk({tag, "_ovr"}, {63'd0, o_overrun}, 64'd0);
  endtask

  // One clock: drive at negedge, check, update the model at the posedge.
  task automatic cycle(input bit stb, input bit rdy);
    bit busy;
    bit lst;
    i_C_valid = stb;
    i_ready   = rdy;
    if (stb) i_C = pack_frame();
    else     i_C = ~i_C;
    #1;
    check_outputs();
    if (o_valid && rdy) n_beats++;
    @(posedge i_clk);
    busy = (exp_q.size() > 0);
    if (busy && rdy) begin
      lst = exp_q[0].last;
      void'(exp_q.pop_front());
      if (lst) m_cnt++;
    end
    if (stb) begin
      if (busy) m_ovr = 1'b1;
      else      push_frame();
    end
    @(negedge i_clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) cycle(1'b0, 1'b1);
    if (exp_q.size() > 0) chk("drain_timeout", 64'd1, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    i_C_valid = 1'b0;
    #2 i_rst = 1'b1;
    #1 check_reset(tag);
    exp_q.delete();
    m_cnt = '0;
    m_ovr = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  initial begin
    bit issued;
    int left;
    bit stb;
    n_checks = 0;
    n_errors = 0;
    m_cnt    = '0;
    m_ovr    = 1'b0;

    // Power-on reset
    repeat (2) @(negedge i_clk);
    check_reset("por");
    i_rst = 1'b0;

    // Ordering: element k = k+1
    for (int k = 0; k < NN; k++) elems[k] = 64'(k + 1);
    n_beats = 0;
    cycle(1'b1, 1'b1);
    drain();
    cycle(1'b0, 1'b1);
    chk("order_beats", 64'(n_beats), 64'd9);
    chk("order_fcnt", {48'd0, o_frame_cnt}, 64'd1);

    // Backpressure: ready pattern 1,0,0 repeating
    fill_const(64'hFFFF_FFFE_0000_0001);
    n_beats = 0;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) cycle(1'b0, (i % 3) == 0);
    cycle(1'b0, 1'b1);
    chk("bp_beats", 64'(n_beats), 64'd9);
    chk("bp_empty", 64'(exp_q.size()), 64'd0);

    // Overrun: second strobe during beat 4 must be dropped
    fill_rand();
    n_beats = 0;
    issued  = 1'b0;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) begin
      stb = (n_beats == 3) && !issued;
      if (stb) begin
        fill_const(64'hAAAA_AAAA_AAAA_AAAA);
        issued = 1'b1;
      end
      cycle(stb, 1'b1);
    end
    repeat (3) cycle(1'b0, 1'b1);
    chk("ovr_sticky", {63'd0, o_overrun}, 64'd1);
    chk("ovr_fcnt", {48'd0, o_frame_cnt}, 64'd3);

    // Reset asserted off-edge at beat 5, then a fresh frame from (0,0)
    fill_rand();
    n_beats = 0;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20 && n_beats < 5; i++) cycle(1'b0, 1'b1);
    do_reset("mid");
    fill_rand();
    cycle(1'b1, 1'b1);
    drain();
    cycle(1'b0, 1'b1);

    // Back-to-back frames: strobe as soon as ready returns
    do_reset("b2b_rst");
    left = 2;
    for (int i = 0; i < 60 && (left > 0 || exp_q.size() > 0); i++) begin
      stb = (exp_q.size() == 0) && (left > 0);
      if (stb) begin
        fill_rand();
        left--;
      end
      cycle(stb, 1'b1);
    end
    cycle(1'b0, 1'b1);
    chk("b2b_fcnt", {48'd0, o_frame_cnt}, 64'd2);
    chk("b2b_ovr", {63'd0, o_overrun}, 64'd0);

    // All-zero then all-ones frames
    do_reset("zo_rst");
    n_beats = 0;
    fill_const('0);
    cycle(1'b1, 1'b1);
    drain();
    fill_const('1);
    cycle(1'b1, 1'b1);
    drain();
    cycle(1'b0, 1'b1);
    chk("zo_beats", 64'(n_beats), 64'd18);
    chk("zo_fcnt", {48'd0, o_frame_cnt}, 64'd2);

    // Random traffic: strobes, backpressure, overruns
    for (int i = 0; i < 400; i++) begin
      stb = ($urandom_range(0, 7) == 0);
      if (stb) fill_rand();
      cycle(stb, $urandom_range(0, 3) != 0);
    end
    drain();
    cycle(1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
